// File: rtl/pwm_pulse_decoder.sv
// pwm_pulse_decoder
// Measures a square/PWM waveform: on every rising edge of pwm_in it reports the
// previous period's high time and period length in clk cycles, counts complete
// periods per burst, and flags the end of a burst after TIMEOUT idle cycles.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   pwm_in       in   waveform under measurement (asynchronous, synchronized here)
//   meas_valid   out  one-cycle pulse, high_time/period updated this cycle
//   high_time    out  high cycles in the last complete period
//   period       out  cycles between the last two rising edges
//   stage_count  out  complete periods in the current burst, saturates at 31
//   burst_active out  high from the first rising edge of a burst until timeout
//   burst_done   out  one-cycle pulse at timeout when stage_count is non-zero
module pwm_pulse_decoder #(
    parameter int unsigned CNT_W   = 19,
    parameter int unsigned TIMEOUT = 400000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic [4:0]       stage_count,
    output logic             burst_active,
    output logic             burst_done
);

    localparam int unsigned     STAGE_W   = 5;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(31);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        WAIT_RISE = 2'd2
    } state_e;

    logic               s1_q, s2_q, sp_q;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   high_time_q, high_time_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               meas_valid_q, meas_valid_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    logic               rise_c, fall_c, timeout_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [STAGE_W-1:0] stage_inc_c;

    // Edge detect on the synchronized level
    assign rise_c    = s2_q & ~sp_q;
    assign fall_c    = ~s2_q & sp_q;
    assign timeout_c = (cnt_q == TIMEOUT_C);

    // Counter holds at TIMEOUT so an edge that wins the timeout cycle cannot overflow it
    assign cnt_inc_c   = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
    assign stage_inc_c = (stage_q == STAGE_MAX) ? stage_q : stage_q + STAGE_W'(1);

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        high_time_d  = high_time_q;
        period_d     = period_q;
        stage_d      = stage_q;
        active_d     = active_q;
        meas_valid_d = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_c) begin
                    state_d  = WAIT_FALL;
                    cnt_d    = CNT_W'(1);
                    stage_d  = '0;
                    active_d = 1'b1;
                end
            end
            WAIT_FALL: begin
                cnt_d = cnt_inc_c;
                if (fall_c) begin
                    hcnt_d  = cnt_q;
                    state_d = WAIT_RISE;
                end else if (timeout_c) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    active_d = 1'b0;
                    done_d   = (stage_q != '0);
                end
            end
            WAIT_RISE: begin
                cnt_d = cnt_inc_c;
                if (rise_c) begin
                    high_time_d  = hcnt_q;
                    period_d     = cnt_q;
                    meas_valid_d = 1'b1;
                    stage_d      = stage_inc_c;
                    cnt_d        = CNT_W'(1);
                    state_d      = WAIT_FALL;
                end else if (timeout_c) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    active_d = 1'b0;
                    done_d   = (stage_q != '0);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // All state, synchronizer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            sp_q         <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            high_time_q  <= '0;
            period_q     <= '0;
            stage_q      <= '0;
            meas_valid_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            s1_q         <= pwm_in;
            s2_q         <= s1_q;
            sp_q         <= s2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            high_time_q  <= high_time_d;
            period_q     <= period_d;
            stage_q      <= stage_d;
            meas_valid_q <= meas_valid_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    assign meas_valid   = meas_valid_q;
    assign high_time    = high_time_q;
    assign period       = period_q;
    assign stage_count  = stage_q;
    assign burst_active = active_q;
    assign burst_done   = done_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Scoreboard bench for pwm_pulse_decoder. The driver feeds pwm_in one sample per
// clock and a reference model working on sampled edge times predicts every
// output event (burst start, measurement, burst end); a separate monitor pops
// and compares whenever the DUT shows an event.
module tb_pwm_pulse_decoder;

    localparam int CNT_W = 19;
    localparam int T     = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic [4:0]       stage_count;
    logic             burst_active;
    logic             burst_done;

    pwm_pulse_decoder #(.CNT_W(CNT_W), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .meas_valid   (meas_valid),
        .high_time    (high_time),
        .period       (period),
        .stage_count  (stage_count),
        .burst_active (burst_active),
        .burst_done   (burst_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic mv;
        logic bd;
        logic ba;
        int   st;
        int   ht;
        int   pd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: times are posedge indices at which pwm_in was sampled
    logic m_prev;
    logic m_active;
    logic m_wf;
    int   m_r, m_h, m_stage, m_ht, m_pd;

    function automatic void push_ev(int c, logic mv, logic bd, logic ba, int st, int ht, int pd);
        exp_t e;
        e.cyc = c; e.mv = mv; e.bd = bd; e.ba = ba; e.st = st; e.ht = ht; e.pd = pd;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_prev = 1'b0; m_active = 1'b0; m_wf = 1'b0;
        m_r = 0; m_h = 0; m_stage = 0; m_ht = 0; m_pd = 0;
    endfunction

    // A sample at posedge n shows up on the outputs after posedge n+2; the burst
    // ends when no rising edge follows the last one within T samples.
    function automatic void model_step(int n, logic v);
        if (m_active && n == m_r + T + 1) begin
            m_active = 1'b0;
            push_ev(n + 1, 1'b0, (m_stage != 0), 1'b0, m_stage, m_ht, m_pd);
        end
        if (v && !m_prev) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_stage  = 0;
                m_r      = n;
                m_wf     = 1'b1;
                push_ev(n + 2, 1'b0, 1'b0, 1'b1, 0, m_ht, m_pd);
            end else if (!m_wf) begin
                m_pd    = n - m_r;
                m_ht    = m_h;
                m_stage = (m_stage >= 31) ? 31 : m_stage + 1;
                m_r     = n;
                m_wf    = 1'b1;
                push_ev(n + 2, 1'b1, 1'b0, 1'b1, m_stage, m_ht, m_pd);
            end
        end else if (!v && m_prev && m_active && m_wf) begin
            m_h  = n - m_r;
            m_wf = 1'b0;
        end
        m_prev = v;
    endfunction

    task automatic drive(input logic v);
        @(negedge clk);
        pwm_in = v;
        model_step(cyc + 1, v);
    endtask

    task automatic pulses(input int n, input int h, input int p);
        for (int i = 0; i < n; i++) begin
            repeat (h) drive(1'b1);
            repeat (p - h) drive(1'b0);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({meas_valid, burst_done, burst_active} !== 3'b000 || stage_count !== 5'd0 ||
            high_time !== '0 || period !== '0) begin
            bad++;
            $display("FAIL %s: got mv=%0b bd=%0b ba=%0b st=%0d ht=%0d pd=%0d, want all zero",
                     name, meas_valid, burst_done, burst_active, stage_count, high_time, period);
        end
    endtask

    // Asynchronous reset between clock edges, then release with pwm_in low
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check_zero("async_reset_clear");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pwm_in = i[0];
            check_zero("reset_hold");
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        model_step(cyc + 1, 1'b0);
    endtask

    // Monitor: every DUT event must match the head of the scoreboard at that cycle
    initial begin
        logic prev_active;
        exp_t e;
        prev_active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_active = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missed_event: want mv=%0b bd=%0b ba=%0b st=%0d at cycle %0d, got nothing by cycle %0d",
                             q[0].mv, q[0].bd, q[0].ba, q[0].st, q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                if (meas_valid || burst_done || burst_active != prev_active) begin
                    total++;
                    if (q.size() == 0 || q[0].cyc != cyc) begin
                        bad++;
                        $display("FAIL unexpected_event: got mv=%0b bd=%0b ba=%0b st=%0d ht=%0d pd=%0d at cycle %0d, want no event",
                                 meas_valid, burst_done, burst_active, stage_count, high_time, period, cyc);
                    end else begin
                        e = q.pop_front();
                        if (meas_valid !== e.mv || burst_done !== e.bd || burst_active !== e.ba ||
                            int'(stage_count) != e.st || int'(high_time) != e.ht || int'(period) != e.pd) begin
                            bad++;
                            $display("FAIL event_cycle_%0d: got mv=%0b bd=%0b ba=%0b st=%0d ht=%0d pd=%0d, want mv=%0b bd=%0b ba=%0b st=%0d ht=%0d pd=%0d",
                                     cyc, meas_valid, burst_done, burst_active, stage_count, high_time, period,
                                     e.mv, e.bd, e.ba, e.st, e.ht, e.pd);
                        end
                    end
                end
                prev_active = burst_active;
            end
        end
    end

    initial begin
        int k, h, l;
        model_reset();

        // Reset held while pwm_in toggles
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pwm_in = i[1];
            check_zero("reset_state");
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        model_step(cyc + 1, 1'b0);
        repeat (5) drive(1'b0);

        // Basic burst: 4 rises 40 apart, 10 high
        pulses(4, 10, 40);
        repeat (T + 10) drive(1'b0);

        // Single pulse: no measurement, no burst_done
        pulses(1, 20, 20);
        repeat (T + 10) drive(1'b0);

        // Minimum widths, saturation, trailing high
        pulses(40, 1, 5);
        repeat (T + 5) drive(1'b1);
        repeat (T + 10) drive(1'b0);

        // Rising edge on the timeout cycle wins
        pulses(3, 10, T);
        pulses(1, 5, 20);
        repeat (T + 10) drive(1'b0);

        // Reset during WAIT_RISE, then a fresh burst
        pulses(2, 10, 30);
        repeat (10) drive(1'b1);
        repeat (5) drive(1'b0);
        mid_reset();
        repeat (3) drive(1'b0);
        pulses(2, 10, 30);
        repeat (T + 10) drive(1'b0);

        // Randomized bursts, with periods clustered near the timeout boundary
        for (int b = 0; b < 15; b++) begin
            k = $urandom_range(0, 35);
            for (int i = 0; i <= k; i++) begin
                h = $urandom_range(1, 20);
                if ($urandom_range(0, 7) == 0) l = $urandom_range(T - h - 1, T - h + 2);
                else                           l = $urandom_range(1, 30);
                repeat (h) drive(1'b1);
                repeat (l) drive(1'b0);
            end
            if ($urandom_range(0, 1) == 1) repeat (T + 5) drive(1'b1);
            repeat (T + 5) drive(1'b0);
        end

        repeat (10) drive(1'b0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending events, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
